// File: rtl/seg7_scan_chaser.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_chaser
// Brief    : Multiplexed DIGITS-wide 7-segment driver. It shows either a segment
//            chase pattern or per-digit hex. Optional macro SEG7_DP_EN adds decimal points.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_chaser #(
  parameter int DIGITS   = 8,
  parameter int STEP_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     en,
  input  logic                  mode,
  input  logic                  dir,
  input  logic                  pause,
  input  logic [4*DIGITS-1:0]   data,
`ifdef SEG7_DP_EN
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  dp,
`endif
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic [DIGITS-1:0]     se
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [STEP_W-1:0] C_STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0] C_SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [2:0] P_A = 3'd0;
  localparam logic [2:0] P_B = 3'd1;
  localparam logic [2:0] P_C = 3'd2;
  localparam logic [2:0] P_D = 3'd3;
  localparam logic [2:0] P_E = 3'd4;
  localparam logic [2:0] P_F = 3'd5;

  logic [STEP_W-1:0] r_step_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic              w_step_tick;
  logic              w_scan_tick;
  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [5:0]        w_chase;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;
  logic [IDX_W-1:0]  w_first;
  logic [IDX_W-1:0]  w_above;
  logic              w_any;
  logic              w_has_above;
  logic [DIGITS-1:0] w_sel;
  logic              w_en_cur;
  logic [3:0]        w_nib;
  logic              w_dp_cur;
  logic [6:0]        w_hex;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_se;

  assign w_step_tick = (r_step_cnt == C_STEP_LAST);
  assign w_scan_tick = (r_scan_cnt == C_SCAN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_scan_cnt <= '0;
    end else begin
      r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
      r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= P_A;
    else        r_state <= w_state_next;
  end

  // A tick that lands during pause is simply lost.
  always_comb begin
    w_state_next = r_state;
    if (w_step_tick && !pause) begin
      case (r_state)
        P_A:     w_state_next = dir ? P_F : P_B;
        P_B:     w_state_next = dir ? P_A : P_C;
        P_C:     w_state_next = dir ? P_B : P_D;
        P_D:     w_state_next = dir ? P_C : P_E;
        P_E:     w_state_next = dir ? P_D : P_F;
        P_F:     w_state_next = dir ? P_E : P_A;
        default: w_state_next = P_A;
      endcase
    end
  end

  always_comb begin
    w_chase = 6'b000000;
    case (r_state)
      P_A:     w_chase = 6'b000001;
      P_B:     w_chase = 6'b000010;
      P_C:     w_chase = 6'b000100;
      P_D:     w_chase = 6'b001000;
      P_E:     w_chase = 6'b010000;
      P_F:     w_chase = 6'b100000;
      default: w_chase = 6'b000000;
    endcase
  end

  // Next index: lowest enabled digit above idx, else lowest enabled overall (wrap).
  always_comb begin
    w_first     = '0;
    w_above     = '0;
    w_any       = 1'b0;
    w_has_above = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (en[i]) begin
        w_first = IDX_W'(i);
        w_any   = 1'b1;
        if (IDX_W'(i) > r_idx) begin
          w_above     = IDX_W'(i);
          w_has_above = 1'b1;
        end
      end
    end
    w_idx_next = r_idx;
    if (w_scan_tick) begin
      if (w_has_above)  w_idx_next = w_above;
      else if (w_any)   w_idx_next = w_first;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idx <= '0;
    else        r_idx <= w_idx_next;
  end

  always_comb begin
    w_sel    = '0;
    w_nib    = 4'h0;
    w_dp_cur = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel[i] = en[i];
        w_nib    = data[4*i +: 4];
`ifdef SEG7_DP_EN
        w_dp_cur = dp_in[i];
`endif
      end
    end
    w_en_cur = |w_sel;
  end

  always_comb begin
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
  end

  // A disabled current digit blanks both select and segments to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
      r_se  <= '0;
    end else begin
      r_se <= w_sel;
      if (!w_en_cur)  r_seg <= '0;
      else if (mode)  r_seg <= w_hex;
      else            r_seg <= {1'b0, w_chase};
    end
  end

`ifdef SEG7_DP_EN
  logic r_dp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dp <= 1'b0;
    else        r_dp <= mode & w_en_cur & w_dp_cur;
  end
  assign dp = r_dp;
`else
  logic w_unused_dp;
  assign w_unused_dp = w_dp_cur;
`endif

  assign {g, f, e, d, c, b, a} = r_seg;
  assign se = r_se;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_chaser.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_chaser
// Brief    : Scoreboard bench for seg7_scan_chaser against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_chaser;
  localparam int D  = 4;
  localparam int SD = 2;
  localparam int CD = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [D-1:0]   en;
  logic           mode, dir, pause;
  logic [4*D-1:0] data;
  logic [D-1:0]   dp_in;
  logic           dp_out;
  logic           a, b, c, d, e, f, g;
  logic [D-1:0]   se;

  seg7_scan_chaser #(.DIGITS(D), .STEP_DIV(SD), .SCAN_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .pause(pause),
    .data(data),
`ifdef SEG7_DP_EN
    .dp_in(dp_in), .dp(dp_out),
`endif
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .se(se)
  );

`ifndef SEG7_DP_EN
  assign dp_out = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   seg;
    logic [D-1:0] se;
    logic         dp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: chase position 0..5, scanned digit index, two divide counters.
  int m_pos, m_idx, m_step, m_scan;

  always @(posedge clk) begin
    exp_t x;
    int en_i, cur, cand;
    x.seg = '0; x.se = '0; x.dp = 1'b0;
    if (!rst_n) begin
      m_pos = 0; m_idx = 0; m_step = 0; m_scan = 0;
    end else begin
      en_i = int'(en);
      cur  = (en_i >> m_idx) & 1;
      if (cur != 0) begin
        x.se = D'(1 << m_idx);
        if (mode) x.seg = hex_tab[(int'(data) >> (4 * m_idx)) & 15];
        else      x.seg = 7'(1 << m_pos);
`ifdef SEG7_DP_EN
        x.dp = mode && (((int'(dp_in) >> m_idx) & 1) != 0);
`endif
      end
      if (m_step == SD - 1) begin
        m_step = 0;
        if (!pause) m_pos = dir ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
      end else m_step++;
      if (m_scan == CD - 1) begin
        m_scan = 0;
        for (int k = 1; k < D; k++) begin
          cand = (m_idx + k) % D;
          if (((en_i >> cand) & 1) != 0) begin
            m_idx = cand;
            break;
          end
        end
      end else m_scan++;
    end
    q.push_back(x);
  end

  always @(posedge clk) begin
    exp_t x;
    #1;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL queue_empty t=%0t got=none want=entry", $time);
    end else begin
      x = q.pop_front();
      if ({g, f, e, d, c, b, a} !== x.seg || se !== x.se || dp_out !== x.dp) begin
        bad++;
        $display("FAIL outputs t=%0t got seg=%h se=%b dp=%b want seg=%h se=%b dp=%b",
                 $time, {g, f, e, d, c, b, a}, se, dp_out, x.seg, x.se, x.dp);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 4'hF; mode = 1'b0; dir = 1'b0; pause = 1'b0;
    data = '0; dp_in = '0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(20);
    dir = 1'b1;
    wait_cycles(8);
    pause = 1'b1;
    wait_cycles(10);
    pause = 1'b0; dir = 1'b0;
    mode = 1'b1; data = 16'hA5C0; en = 4'b0101;
    wait_cycles(12);
    en = 4'b0000;
    wait_cycles(7);
    en = 4'b1000;
    wait_cycles(8);
    en = 4'hF; mode = 1'b0;
    wait_cycles(7);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({g, f, e, d, c, b, a} !== 7'h00 || se !== '0 || dp_out !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got seg=%h se=%b dp=%b want all zero",
               {g, f, e, d, c, b, a}, se, dp_out);
    end
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(10);
    mode = 1'b1; dp_in = 4'b0100;
    wait_cycles(12);
    mode = 1'b0;
    wait_cycles(6);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) en = D'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      pause = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) data = (4 * D)'($urandom);
      dp_in = D'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    wait_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
